// File: rtl/calcutec_pkg.sv
// Shared types and constants for the ALU issue path.
package calcutec_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_LSL = 4'd4;
  localparam logic [3:0] ALU_LSR = 4'd5;

  typedef struct packed {
    logic [DATA_W-1:0] dat1;
    logic [DATA_W-1:0] dat2;
    logic [3:0]        control;
    logic [ADDR_W-1:0] rd;
    logic              set;
  } issue_bundle_t;

  function automatic logic [NREG-1:0] onehot(
    input logic [ADDR_W-1:0] idx
  );
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 16x32 register file, two async reads, one sync write.
// RF_BYPASS_EN: reads of the index being written return wb data.
module reg_file
  import calcutec_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NR = NREG,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

`ifdef RF_BYPASS_EN
  assign rd1 = (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = (we && wa == ra2) ? wd : mem[ra2];
`else
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch / issue stage feeding the ALU, with scoreboard.
// RF_BYPASS_EN: same-cycle writeback forwarding and hazard release.
module alu_issue_stage
  import calcutec_pkg::*;
#(
  parameter int DATA_W = calcutec_pkg::DATA_W,
  parameter int NREG   = calcutec_pkg::NREG,
  parameter int ADDR_W = calcutec_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rn,
  input  logic [ADDR_W-1:0] in_rm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              in_set,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dat1,
  output logic [DATA_W-1:0] out_dat2,
  output logic [3:0]        out_control,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_set,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_eff;
  logic [NREG-1:0]   wb_mask;
  logic [NREG-1:0]   set_mask;
  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;
  logic              hazard;
  logic              accept;
  issue_bundle_t     bundle;
  issue_bundle_t     nxt;

  reg_file #(
    .DW(DATA_W),
    .NR(NREG),
    .AW(ADDR_W)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(in_rn),
    .ra2(in_rm),
    .rd1(rn_val),
    .rd2(rm_val),
    .we (wb_en),
    .wa (wb_addr),
    .wd (wb_data)
  );

  assign wb_mask = wb_en ? onehot(wb_addr) : '0;

`ifdef RF_BYPASS_EN
  assign pend_eff = pend & ~wb_mask;
`else
  assign pend_eff = pend;
`endif

  assign hazard = in_valid &
                  (pend_eff[in_rn] |
                   (~in_use_imm & pend_eff[in_rm]) |
                   pend_eff[in_rd]);

  assign in_ready = ~rst & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign set_mask = accept ? onehot(in_rd) : '0;

  always_comb begin
    nxt         = '0;
    nxt.dat1    = rn_val;
    nxt.dat2    = in_use_imm ? in_imm : rm_val;
    nxt.control = in_op;
    nxt.rd      = in_rd;
    nxt.set     = in_set;
  end

  // set_mask applied after the clear so a new claim wins over writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~wb_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      bundle    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bundle    <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_dat1    = bundle.dat1;
  assign out_dat2    = bundle.dat2;
  assign out_control = bundle.control;
  assign out_rd      = bundle.rd;
  assign out_set     = bundle.set;
  assign busy        = |pend;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage (directed + random vs model).
// Honours RF_BYPASS_EN for forwarding expectations.
module tb_alu_issue_stage;
  import calcutec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_rd;
  logic [3:0]  in_rn;
  logic [3:0]  in_rm;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic        in_set;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_dat1;
  logic [31:0] out_dat2;
  logic [3:0]  out_control;
  logic [3:0]  out_rd;
  logic        out_set;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_set(in_set),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dat1(out_dat1), .out_dat2(out_dat2),
    .out_control(out_control), .out_rd(out_rd), .out_set(out_set),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [73:0] outs();
    return {out_valid, out_dat1, out_dat2, out_control, out_rd, out_set};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_op      = '0;
    in_rd      = '0;
    in_rn      = '0;
    in_rm      = '0;
    in_imm     = '0;
    in_use_imm = 1'b0;
    in_set     = 1'b0;
    wb_en      = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    out_ready  = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rn, input logic [3:0] rm,
                       input logic [31:0] imm, input logic ui,
                       input logic st);
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_rn      = rn;
    in_rm      = rm;
    in_imm     = imm;
    in_use_imm = ui;
    in_set     = st;
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_en   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: valid/busy=%b want 00", {out_valid, busy});
    end
    wb(4'd1, 32'h0000_00AB);
    out_ready = 1'b0;
    issue(ALU_MUL, 4'd9, 4'd1, 4'd0, 32'd7, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs() !== {1'b1, 32'hAB, 32'h7, 4'd2, 4'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_pre_issue: got %h want %h", outs(),
               {1'b1, 32'hAB, 32'h7, 4'd2, 4'd9, 1'b1});
    end
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({outs(), busy, in_ready} !== 76'd0) begin
      n_fail++;
      $display("FAIL reset_async: outs=%h busy=%b rdy=%b want all 0",
               outs(), busy, in_ready);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    issue(ALU_ADD, 4'd2, 4'd1, 4'd1, 32'h0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs() !== {1'b1, 32'h0, 32'h0, 4'd0, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_regs_cleared: got %h want %h", outs(),
               {1'b1, 32'h0, 32'h0, 4'd0, 4'd2, 1'b0});
    end
  endtask

  task automatic test_load_issue();
    do_reset();
    wb(4'd3, 32'h0000_0010);
    issue(ALU_ADD, 4'd4, 4'd3, 4'd0, 32'd5, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({outs(), busy} !== {1'b1, 32'h10, 32'h5, 4'd0, 4'd4, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_issue: got %h want %h", {outs(), busy},
               {1'b1, 32'h10, 32'h5, 4'd0, 4'd4, 1'b0, 1'b1});
    end
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue(ALU_ADD, 4'd4, 4'd0, 4'd0, 32'd1, 1'b1, 1'b0);
    tick();
    issue(ALU_SUB, 4'd5, 4'd4, 4'd0, 32'd1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_stall_0: got %b want 0", in_ready);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_stall_1: got %b want 0", in_ready);
    end
    wb_en   = 1'b1;
    wb_addr = 4'd4;
    wb_data = 32'h15;
    #1;
`ifdef RF_BYPASS_EN
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_wb_cycle_ready: got %b want 1", in_ready);
    end
    tick();
    wb_en    = 1'b0;
    in_valid = 1'b0;
`else
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_wb_cycle_ready: got %b want 0", in_ready);
    end
    tick();
    wb_en = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_after_wb_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
`endif
    n_checks++;
    if (outs() !== {1'b1, 32'h15, 32'h1, 4'd1, 4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL raw_issue: got %h want %h", outs(),
               {1'b1, 32'h15, 32'h1, 4'd1, 4'd5, 1'b0});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    wb(4'd1, 32'h11);
    wb(4'd2, 32'h22);
    out_ready = 1'b0;
    issue(ALU_SUB, 4'd3, 4'd1, 4'd2, 32'h0, 1'b0, 1'b1);
    tick();
    issue(ALU_LSR, 4'd6, 4'd2, 4'd0, 32'h99, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({outs(), in_ready} !==
          {1'b1, 32'h11, 32'h22, 4'd1, 4'd3, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got %h want %h", c, {outs(), in_ready},
                 {1'b1, 32'h11, 32'h22, 4'd1, 4'd3, 1'b1, 1'b0});
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs() !== {1'b1, 32'h22, 32'h99, 4'd5, 4'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_second: got %h want %h", outs(),
               {1'b1, 32'h22, 32'h99, 4'd5, 4'd6, 1'b0});
    end
    tick();
    n_checks++;
    if ({out_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_no_dup: valid/busy=%b want 01", {out_valid, busy});
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    issue(ALU_OR, 4'd7, 4'd0, 4'd0, 32'h3, 1'b1, 1'b0);
    wb_en   = 1'b1;
    wb_addr = 4'd7;
    wb_data = 32'h5;
    tick();
    idle();
    n_checks++;
    if ({out_valid, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL setwins_busy: valid/busy=%b want 11", {out_valid, busy});
    end
    issue(ALU_ADD, 4'd8, 4'd7, 4'd0, 32'h0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL setwins_pend7: ready=%b want 0", in_ready);
    end
    in_valid = 1'b0;
    wb(4'd7, 32'h77);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL setwins_clear: busy=%b want 0", busy);
    end
  endtask

  task automatic test_imm_bypass();
    do_reset();
    issue(ALU_ADD, 4'd2, 4'd0, 4'd0, 32'h0, 1'b1, 1'b0);
    tick();
    issue(ALU_LSL, 4'd8, 4'd1, 4'd2, 32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL imm_reg_rm_stall: ready=%b want 0", in_ready);
    end
    in_use_imm = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_no_stall: ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (outs() !== {1'b1, 32'h0, 32'hDEAD_BEEF, 4'd4, 4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL imm_issue: got %h want %h", outs(),
               {1'b1, 32'h0, 32'hDEAD_BEEF, 4'd4, 4'd8, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [31:0] m_reg [16];
    bit          m_pend [16];
    bit          m_v;
    logic [73:0] m_out;
    bit          pe [16];
    bit          haz, rdy, acc, any;
    logic [31:0] v1, v2;
    int          start;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_v   = 1'b0;
    m_out = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_op      = 4'($urandom_range(0, 15));
      in_rd      = 4'($urandom_range(0, 15));
      in_rn      = 4'($urandom_range(0, 15));
      in_rm      = 4'($urandom_range(0, 15));
      in_imm     = $urandom;
      in_use_imm = $urandom_range(0, 1) == 1;
      in_set     = $urandom_range(0, 1) == 1;
      out_ready  = ($urandom_range(0, 9) < 7);
      wb_en      = ($urandom_range(0, 2) != 0);
      wb_data    = $urandom;
      start      = $urandom_range(0, 15);
      wb_addr    = 4'(start);
      for (int k = 0; k < 16; k++) begin
        if (m_pend[(start + k) % 16]) begin
          wb_addr = 4'((start + k) % 16);
          break;
        end
      end
      #1;
      for (int i = 0; i < 16; i++)
        pe[i] = m_pend[i] && !(BYP && wb_en && wb_addr == i);
      haz = in_valid && (pe[in_rn] || (!in_use_imm && pe[in_rm]) ||
                         pe[in_rd]);
      rdy = !haz && (!m_v || out_ready);
      acc = in_valid && rdy;
      n_checks++;
      if (in_ready !== rdy) begin
        n_fail++;
        $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, rdy);
      end
      v1 = (BYP && wb_en && wb_addr == in_rn) ? wb_data : m_reg[in_rn];
      v2 = (BYP && wb_en && wb_addr == in_rm) ? wb_data : m_reg[in_rm];
      if (in_use_imm) v2 = in_imm;
      tick();
      if (acc) begin
        m_v   = 1'b1;
        m_out = {1'b1, v1, v2, in_op, in_rd, in_set};
      end else if (out_ready) begin
        m_v = 1'b0;
      end
      if (wb_en) begin
        m_reg[wb_addr]  = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (acc) m_pend[in_rd] = 1'b1;
      any = 1'b0;
      for (int i = 0; i < 16; i++) any |= m_pend[i];
      n_checks++;
      if ({out_valid, busy} !== {m_v, any}) begin
        n_fail++;
        $display("FAIL rand_valid_busy c=%0d: got %b want %b", c,
                 {out_valid, busy}, {m_v, any});
      end
      if (m_v) begin
        n_checks++;
        if (outs() !== m_out) begin
          n_fail++;
          $display("FAIL rand_bundle c=%0d: got %h want %h", c, outs(),
                   m_out);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_issue();
    test_raw_stall();
    test_backpressure();
    test_set_wins();
    test_imm_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-fetch/issue stage directly upstream of the ALU.
- Accepts decoded instructions, reads two operands from an internal 16x32 register file, selects immediate vs register for the second operand, and registers dat1/dat2/control/set for the ALU.
- A per-register scoreboard stalls issue while a source or destination register still has a result in flight; the downstream writeback port writes results back.

Parameters:
- DATA_W, 32, operand/register width.
- NREG, 16, number of architectural registers.
- ADDR_W, 4, register index width (log2 NREG).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- in_op  in  4  ALU control code (0 add, 1 sub, 2 mul, 3 or, 4 lsl, 5 lsr).
- in_rd  in  ADDR_W  destination register.
- in_rn  in  ADDR_W  first source register.
- in_rm  in  ADDR_W  second source register.
- in_imm  in  DATA_W  immediate operand.
- in_use_imm  in  1  1: dat2 = in_imm; 0: dat2 = R[in_rm].
- in_set  in  1  update ALU flags.
- out_valid  out  1  issued bundle valid.
- out_ready  in  1  ALU/execute stage consumes bundle.
- out_dat1  out  DATA_W  operand 1 to ALU.
- out_dat2  out  DATA_W  operand 2 to ALU.
- out_control  out  4  ALU control.
- out_rd  out  ADDR_W  destination tag, carried to writeback.
- out_set  out  1  flag-update enable to ALU.
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback value.
- busy  out  1  OR of all scoreboard bits.

Behaviour:
- **Reset** (async, rst=1):
  - All registers = 0; scoreboard = 0.
  - out_valid = 0; out_dat1/out_dat2 = 0; out_control = 0; out_rd = 0; out_set = 0.
  - in_ready forced 0 while rst is high.
  - An in-flight bundle is discarded, not replayed.
- **Hazard** = in_valid AND any of:
  - pend[in_rn];
  - !in_use_imm AND pend[in_rm];
  - pend[in_rd] (WAW).
- **Ready/accept:**
  - in_ready = !rst AND !hazard AND (!out_valid OR out_ready).
  - Accept = in_valid AND in_ready.
  - On accept the output register loads: dat1 = R[in_rn]; dat2 = in_use_imm ? in_imm : R[in_rm]; control, rd and set are copied. Set pend[in_rd] = 1 and out_valid = 1.
- **Latency:** one cycle from accept to out_valid.
- **Downstream handshake:**
  - If out_valid AND out_ready with no new accept, out_valid -> 0 next cycle.
  - Back-to-back issue sustains one instruction per cycle when hazard-free.
- **Stall:** while out_valid AND !out_ready, all out_* hold stable.
- **Writeback:**
  - wb_en writes R[wb_addr] = wb_data and clears pend[wb_addr] at the same edge.
  - Simultaneous accept setting and wb clearing the same index: set wins (pend stays 1).
- **Op codes:** in_op values 6..15 pass through unchanged (the ALU yields -1); no checking here.
- **Widths:** in_imm is passed unmodified, no extension.
- wb_en with pend[wb_addr] = 0 still writes the register (used for initial loads).

Optional Feature:
- Macro: RF_BYPASS_EN.
- **Defined:**
  - Same-cycle write-first forwarding: a source index equal to wb_addr with wb_en = 1 reads wb_data.
  - pend for that index counts as cleared for this cycle's hazard check, so a dependent instruction issues in the writeback cycle.
- **Undefined:**
  - Reads return the pre-write value, and hazard uses the registered pend.
  - A dependent instruction issues one cycle after writeback; throughput on a RAW chain drops by one cycle per dependency.

Decomposition:
- **Package calcutec_pkg:**
  - DATA_W and ADDR_W constants.
  - ALU op-code localparams ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_OR=3, ALU_LSL=4, ALU_LSR=5.
  - typedef issue_bundle_t {dat1, dat2, control, rd, set}.
- **Sub-module reg_file:** 16x32, two async read ports, one sync write port, RF_BYPASS_EN-dependent forwarding.
- Scoreboard and handshake logic stay in alu_issue_stage.

Test Plan:
- **Reset value:** rst pulse mid-stall with out_valid = 1 -> out_valid = 0, busy = 0, all out_* = 0 immediately (async); in_ready = 1 on the first cycle after release.
- **Load and issue:** wb R3 = 0x0000_0010, then issue op=0 rn=3 use_imm imm=5 rd=4 -> next cycle out_dat1 = 0x10, out_dat2 = 5, out_control = 0, out_rd = 4, pend[4] = 1.
- **RAW stall:** issue rd=4, then rn=4 -> in_ready = 0 until wb_en addr=4 data=0x15. Bypass on: issues the same cycle with dat1 = 0x15. Bypass off: issues the next cycle with dat1 = 0x15.
- **Backpressure:** out_ready = 0 for 3 cycles with a second valid instruction waiting -> out_* hold stable, in_ready = 0; out_ready = 1 -> second bundle appears the next cycle, with no loss or duplication.
- **Set-wins collision:** wb_en addr=7 in the same cycle as accept of rd=7 -> pend[7] = 1 afterwards, busy = 1.
- **Immediate bypasses scoreboard:** pend[2] = 1, issue rn=1 rm=2 use_imm=1 -> no stall, out_dat2 = imm.
